// File: rtl/conv_win_sched_if.sv
// Handshake/bus bundle for conv_win_sched: start/config, SRAM read port, window FIFO and PE handoff.
// WIN_SCHED_PERF_CNT_EN adds the stall/window counters and overflow flag.
interface conv_win_sched_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 8
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [DIM_W-1:0]  img_w;
   logic [DIM_W-1:0]  img_h;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              fifo_enq;
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_full;
   logic              fifo_deq;
   logic              win_valid;
   logic              pe_ready;
   logic              busy;
   logic              done;
`ifdef WIN_SCHED_PERF_CNT_EN
   logic [31:0]       stall_cnt;
   logic [31:0]       win_cnt;
   logic              err_ovf;
`endif

   modport master (
      input  start, base_addr, img_w, img_h, rd_data, fifo_full, pe_ready,
      output rd_en, rd_addr, fifo_enq, fifo_data, fifo_deq, win_valid, busy, done
`ifdef WIN_SCHED_PERF_CNT_EN
      , output stall_cnt, win_cnt, err_ovf
`endif
   );

   modport slave (
      output start, base_addr, img_w, img_h, rd_data, fifo_full, pe_ready,
      input  rd_en, rd_addr, fifo_enq, fifo_data, fifo_deq, win_valid, busy, done
`ifdef WIN_SCHED_PERF_CNT_EN
      , input stall_cnt, win_cnt, err_ovf
`endif
   );
endinterface

// File: rtl/conv_win_sched.sv
// 3x3 stride-1 window sequencer: fetches 9 pixels per window into the window FIFO, then hands it to the PE array.
// Optional perf counters (stall/window count, overflow flag) under WIN_SCHED_PERF_CNT_EN.
module conv_win_sched #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 8
) (
   input logic              clk,
   input logic              rst,
   conv_win_sched_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, ISSUE, DONE} state_t;

   state_t            state, nxt;
   logic [ADDR_W-1:0] base;
   logic [DIM_W-1:0]  w, h, ox, oy;
   logic [1:0]        kx, ky;
   logic              enq_q;
   logic              rd_en, win_valid, deq;
   logic              last_k, last_x, last_win, accept;
   logic [ADDR_W-1:0] row, col;

   assign accept   = (state == IDLE) && bus.start;
   assign last_k   = (kx == 2'd2) && (ky == 2'd2);
   assign last_x   = (ox == w - DIM_W'(3));
   assign last_win = last_x && (oy == h - DIM_W'(3));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:  if (bus.start)
                   nxt = (bus.img_w < DIM_W'(3) || bus.img_h < DIM_W'(3)) ? DONE : FETCH;
         FETCH: if (last_k) nxt = DRAIN;
         DRAIN: nxt = ISSUE;
         ISSUE: if (deq) nxt = last_win ? DONE : FETCH;
         DONE:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_en     = (state == FETCH);
      win_valid = (state == ISSUE) && bus.fifo_full;
      deq       = win_valid && bus.pe_ready;
      row       = ADDR_W'(oy) + ADDR_W'(ky);
      col       = ADDR_W'(ox) + ADDR_W'(kx);
      bus.rd_en     = rd_en;
      bus.rd_addr   = rd_en ? base + row * ADDR_W'(w) + col : '0;
      bus.win_valid = win_valid;
      bus.fifo_deq  = deq;
      bus.busy      = (state == FETCH) || (state == DRAIN) || (state == ISSUE);
      bus.done      = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         base  <= '0;
         w     <= '0;
         h     <= '0;
         ox    <= '0;
         oy    <= '0;
         kx    <= '0;
         ky    <= '0;
         enq_q <= 1'b0;
      end else begin
         enq_q <= rd_en;
         if (accept) begin
            base <= bus.base_addr;
            w    <= bus.img_w;
            h    <= bus.img_h;
            ox   <= '0;
            oy   <= '0;
            kx   <= '0;
            ky   <= '0;
         end
         // kx fastest; both wrap to 0 after (2,2) so the next window starts clean
         if (state == FETCH) begin
            if (kx == 2'd2) begin
               kx <= '0;
               ky <= (ky == 2'd2) ? 2'd0 : ky + 2'd1;
            end else begin
               kx <= kx + 2'd1;
            end
         end
         if (deq) begin
            if (last_x) begin
               ox <= '0;
               oy <= oy + DIM_W'(1);
            end else begin
               ox <= ox + DIM_W'(1);
            end
         end
      end
   end

`ifdef WIN_SCHED_PERF_CNT_EN
   logic [31:0] stall_cnt, win_cnt;
   logic        err_ovf;
   logic        enq;

   // A full FIFO while fetching means the consumer lost sync; drop the write rather than corrupt
   assign enq = enq_q && !bus.fifo_full;

   always_ff @(posedge clk) begin
      if (rst || accept) begin
         stall_cnt <= '0;
         win_cnt   <= '0;
         err_ovf   <= 1'b0;
      end else begin
         if (win_valid && !bus.pe_ready) stall_cnt <= stall_cnt + 32'd1;
         if (deq) win_cnt <= win_cnt + 32'd1;
         if (state == FETCH && bus.fifo_full) err_ovf <= 1'b1;
      end
   end

   assign bus.stall_cnt = stall_cnt;
   assign bus.win_cnt   = win_cnt;
   assign bus.err_ovf   = err_ovf;
`else
   logic enq;
   assign enq = enq_q;
`endif

   assign bus.fifo_enq  = enq;
   assign bus.fifo_data = enq ? bus.rd_data : '0;
endmodule

// File: tb/tb_conv_win_sched.sv
// Scoreboard bench for conv_win_sched: SRAM returns addr[7:0], FIFO model goes full after 9 enqueues.
module tb_conv_win_sched;
   localparam int DATA_W = 8, ADDR_W = 16, DIM_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0, c0 = 0, fcnt = 0;
   int   checks = 0, failures = 0;
   bit   done_seen = 1'b0;

   logic [15:0] exp_addr[$];
   logic [7:0]  exp_data[$];
   int          exp_deq[$];
   int          exp_done[$];

   // 4x4 map at 0x100, four windows in raster order
   localparam logic [15:0] T1 [36] = '{
      16'h100, 16'h101, 16'h102, 16'h104, 16'h105, 16'h106, 16'h108, 16'h109, 16'h10A,
      16'h101, 16'h102, 16'h103, 16'h105, 16'h106, 16'h107, 16'h109, 16'h10A, 16'h10B,
      16'h104, 16'h105, 16'h106, 16'h108, 16'h109, 16'h10A, 16'h10C, 16'h10D, 16'h10E,
      16'h105, 16'h106, 16'h107, 16'h109, 16'h10A, 16'h10B, 16'h10D, 16'h10E, 16'h10F};

   conv_win_sched_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();
   conv_win_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial bus.rd_data = '0;
   always @(posedge clk) if (bus.rd_en) bus.rd_data <= bus.rd_addr[7:0];

   always @(posedge clk) begin
      if (rst)                                fcnt <= 0;
      else if (bus.fifo_deq)                  fcnt <= 0;
      else if (bus.fifo_enq && fcnt < 9)      fcnt <= fcnt + 1;
   end
   assign bus.fifo_full = (fcnt == 9);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - c0);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an event
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rd_en) begin
            if (exp_addr.size() == 0) check("rd_unexpected", 1, 0);
            else check("rd_addr", bus.rd_addr, exp_addr.pop_front());
         end
         if (bus.fifo_enq) begin
            if (exp_data.size() == 0) check("enq_unexpected", 1, 0);
            else check("fifo_data", bus.fifo_data, exp_data.pop_front());
         end
         if (bus.fifo_deq) begin
            if (exp_deq.size() == 0) check("deq_unexpected", 1, 0);
            else check("deq_cycle", cyc - c0, exp_deq.pop_front());
         end
         if (bus.done) begin
            done_seen = 1'b1;
            if (exp_done.size() == 0) check("done_unexpected", 1, 0);
            else check("done_cycle", cyc - c0, exp_done.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_run(input logic [15:0] base, input int w, input int h);
      bus.base_addr = base;
      bus.img_w     = DIM_W'(w);
      bus.img_h     = DIM_W'(h);
      bus.start     = 1'b1;
      c0            = cyc;
      done_seen     = 1'b0;
      tick();
      bus.start     = 1'b0;
   endtask

   // Reference: raster windows, 11 cycles each, optional stall on window 1
   task automatic expect_run(input logic [15:0] base, input int w, input int h, input int stall);
      int nwin = 0, t = 0;
      logic [15:0] a;
      if (w >= 3 && h >= 3)
         for (int oy = 0; oy <= h - 3; oy++)
            for (int ox = 0; ox <= w - 3; ox++) begin
               for (int ky = 0; ky < 3; ky++)
                  for (int kx = 0; kx < 3; kx++) begin
                     a = base + 16'((oy + ky) * w + ox + kx);
                     exp_addr.push_back(a);
                     exp_data.push_back(a[7:0]);
                  end
               t += 11;
               if (nwin == 1) t += stall;
               exp_deq.push_back(t);
               nwin++;
            end
      exp_done.push_back(nwin == 0 ? 1 : t + 1);
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!done_seen && n < budget) begin tick(); n++; end
      check({name, "_done_seen"}, 32'(done_seen), 1);
      check({name, "_leftover"}, 32'(exp_addr.size() + exp_data.size() + exp_deq.size() + exp_done.size()), 0);
   endtask

   task automatic check_idle_outputs(input string name);
      check({name, "_rd_en"},     32'(bus.rd_en), 0);
      check({name, "_rd_addr"},   32'(bus.rd_addr), 0);
      check({name, "_enq"},       32'(bus.fifo_enq), 0);
      check({name, "_fifo_data"}, 32'(bus.fifo_data), 0);
      check({name, "_deq"},       32'(bus.fifo_deq), 0);
      check({name, "_win_valid"}, 32'(bus.win_valid), 0);
      check({name, "_busy"},      32'(bus.busy), 0);
      check({name, "_done"},      32'(bus.done), 0);
   endtask

   initial begin
      logic [15:0] a;
      bus.start = 1'b0; bus.base_addr = '0; bus.img_w = '0; bus.img_h = '0; bus.pe_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check_idle_outputs("reset");

      // 1/2: 4x4 at 0x100, hand vectors; data mirrors addr[7:0]
      for (int i = 0; i < 36; i++) begin
         a = T1[i];
         exp_addr.push_back(a);
         exp_data.push_back(a[7:0]);
      end
      exp_deq.push_back(11); exp_deq.push_back(22); exp_deq.push_back(33); exp_deq.push_back(44);
      exp_done.push_back(45);
      start_run(16'h100, 4, 4);
      check("t1_busy", 32'(bus.busy), 1);
      wait_done("t1", 200);
`ifdef WIN_SCHED_PERF_CNT_EN
      check("t1_win_cnt", bus.win_cnt, 4);
      check("t1_stall_cnt", bus.stall_cnt, 0);
`endif
      tick();

      // 3: PE back-pressure for 20 cycles on window 1 (its ISSUE cycle is 22)
      expect_run(16'h100, 4, 4, 20);
      start_run(16'h100, 4, 4);
      while (cyc < c0 + 22) tick();
      bus.pe_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("t3_win_valid_held", 32'(bus.win_valid), 1);
         check("t3_no_rd", 32'(bus.rd_en), 0);
         tick();
      end
      bus.pe_ready = 1'b1;
      wait_done("t3", 200);
`ifdef WIN_SCHED_PERF_CNT_EN
      check("t3_stall_cnt", bus.stall_cnt, 20);
      check("t3_err_ovf", 32'(bus.err_ovf), 0);
`endif
      tick();

      // 4: degenerate map, done the cycle after the start cycle
      expect_run(16'h000, 2, 5, 0);
      start_run(16'h000, 2, 5);
      check("t4_busy", 32'(bus.busy), 0);
      wait_done("t4", 20);
`ifdef WIN_SCHED_PERF_CNT_EN
      check("t4_win_cnt", bus.win_cnt, 0);
`endif
      tick();

      // 5: reset mid-window 2 (fetch starts at cycle 23), then a 3x3 map
      expect_run(16'h040, 4, 4, 0);
      start_run(16'h040, 4, 4);
      while (cyc < c0 + 28) tick();
      rst = 1'b1;
      exp_addr.delete(); exp_data.delete(); exp_deq.delete(); exp_done.delete();
      tick();
      check_idle_outputs("t5_after_rst");
      rst = 1'b0;
      done_seen = 1'b0;
      repeat (5) tick();
      check("t5_no_done", 32'(done_seen), 0);
      expect_run(16'h010, 3, 3, 0);
      start_run(16'h010, 3, 3);
      wait_done("t5b", 100);
      tick();

      // 6: second start while busy must not resample base/dims
      expect_run(16'h200, 4, 3, 0);
      start_run(16'h200, 4, 3);
      repeat (3) tick();
      bus.base_addr = 16'h000; bus.img_w = 8'd5; bus.img_h = 8'd5; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      wait_done("t6", 200);
`ifdef WIN_SCHED_PERF_CNT_EN
      check("t6_win_cnt", bus.win_cnt, 2);
`endif
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
